pc_predict: RTL and testbench

Parametrised fetch-PC generator with gshare direction prediction and a direct-mapped branch target buffer (BTB). It is the next generation of the PC stage and sits at the front of the pipeline, feeding the PC/IF pipeline register. It adds four things over the fixed-width stage:
- configurable history, PHT and BTB sizes;
- in-block target prediction;
- separate jump handling;
- a configurable fall-through offset for delay-slot ISAs.

---
 rtl/pc_predict.sv | 128 ++++++++++++
 tb/tb_pc_predict.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict.sv
// pc_predict: fetch-PC generator with gshare direction prediction and a
// direct-mapped branch target buffer.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   is_branch_in        - a resolved control transfer is reported this cycle
//   is_jump_in          - the resolved instruction is an unconditional jump
//   is_taken_in         - resolved outcome
//   is_miss_in          - resolved outcome was mispredicted; redirect fetch
//   last_pht_index      - PHT index used when the resolved instruction was fetched
//   inst_pc, target_in  - PC and resolved target of the resolved instruction
//   flush, exc_pc       - exception redirect and its address
//   stall               - hold the fetch PC
//   is_branch_taken     - prediction for pc_out
//   pht_index_out       - PHT index used for pc_out
//   pc_out              - current fetch PC
module pc_predict #(
    parameter int unsigned GHR_WIDTH          = 8,
    parameter int unsigned BTB_ADDR_WIDTH     = 6,
    parameter logic [31:0] RESET_PC           = 32'hbfc00000,
    parameter logic [31:0] FALLTHROUGH_OFFSET = 32'd8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_branch_in,
    input  logic                 is_jump_in,
    input  logic                 is_taken_in,
    input  logic                 is_miss_in,
    input  logic [GHR_WIDTH-1:0] last_pht_index,
    input  logic [31:0]          inst_pc,
    input  logic [31:0]          target_in,
    input  logic                 flush,
    input  logic                 stall,
    input  logic [31:0]          exc_pc,
    output logic                 is_branch_taken,
    output logic [GHR_WIDTH-1:0] pht_index_out,
    output logic [31:0]          pc_out
);

    localparam int unsigned PHT_SIZE = 1 << GHR_WIDTH;
    localparam int unsigned BTB_SIZE = 1 << BTB_ADDR_WIDTH;
    localparam int unsigned TAG_W    = 30 - BTB_ADDR_WIDTH;

    logic [31:0]          pc;
    logic [GHR_WIDTH-1:0] ghr;
    logic [1:0]           pht [PHT_SIZE];

    logic [BTB_SIZE-1:0]  btb_valid;
    logic [BTB_SIZE-1:0]  btb_jump;
    logic [TAG_W-1:0]     btb_tag    [BTB_SIZE];
    logic [31:0]          btb_target [BTB_SIZE];

    logic [BTB_ADDR_WIDTH-1:0] look_idx;
    logic [TAG_W-1:0]          look_tag;
    logic                      btb_hit;
    logic [BTB_ADDR_WIDTH-1:0] upd_idx;
    logic [TAG_W-1:0]          upd_tag;
    logic [31:0]               next_pc;
    logic                      cond_update;

    assign pc_out = pc;

    // Lookup is purely combinational from the registered pc and predictor state.
    always_comb begin
        look_idx        = pc[BTB_ADDR_WIDTH+1:2];
        look_tag        = pc[31:BTB_ADDR_WIDTH+2];
        pht_index_out   = pc[GHR_WIDTH+1:2] ^ ghr;
        btb_hit         = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
        is_branch_taken = btb_hit && (btb_jump[look_idx] || pht[pht_index_out][1]);
    end

    always_comb begin
        upd_idx     = inst_pc[BTB_ADDR_WIDTH+1:2];
        upd_tag     = inst_pc[31:BTB_ADDR_WIDTH+2];
        cond_update = is_branch_in && !is_jump_in;
    end

    // Redirects (flush, mispredict) override stall; stall overrides prediction.
    always_comb begin
        next_pc = pc + 32'd4;
        if (flush)
            next_pc = exc_pc;
        else if (is_miss_in)
            next_pc = is_taken_in ? target_in : (inst_pc + FALLTHROUGH_OFFSET);
        else if (stall)
            next_pc = pc;
        else if (is_branch_taken)
            next_pc = btb_target[look_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ghr       <= '0;
            btb_valid <= '0;
            btb_jump  <= '0;
        end else begin
            pc <= next_pc;
            if (cond_update)
                ghr <= {ghr[GHR_WIDTH-2:0], is_taken_in};
            if (is_branch_in && is_taken_in) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_jump[upd_idx]  <= is_jump_in;
            end
        end
    end

    // Saturating 2-bit counters, all reset to weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            pht <= '{default: 2'b01};
        end else if (cond_update) begin
            if (is_taken_in && pht[last_pht_index] != 2'b11)
                pht[last_pht_index] <= pht[last_pht_index] + 2'd1;
            else if (!is_taken_in && pht[last_pht_index] != 2'b00)
                pht[last_pht_index] <= pht[last_pht_index] - 2'd1;
        end
    end

    // Tag and target need no reset: they are only consulted behind btb_valid.
    always_ff @(posedge clk) begin
        if (!rst && is_branch_in && is_taken_in) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= target_in;
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed self-checking bench for pc_predict.
module tb_pc_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_branch_in;
    logic        is_jump_in;
    logic        is_taken_in;
    logic        is_miss_in;
    logic [7:0]  last_pht_index;
    logic [31:0] inst_pc;
    logic [31:0] target_in;
    logic        flush;
    logic        stall;
    logic [31:0] exc_pc;
    logic        is_branch_taken;
    logic [7:0]  pht_index_out;
    logic [31:0] pc_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_predict #(
        .GHR_WIDTH(8),
        .BTB_ADDR_WIDTH(6),
        .RESET_PC(32'hbfc00000),
        .FALLTHROUGH_OFFSET(32'd8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .is_branch_in(is_branch_in),
        .is_jump_in(is_jump_in),
        .is_taken_in(is_taken_in),
        .is_miss_in(is_miss_in),
        .last_pht_index(last_pht_index),
        .inst_pc(inst_pc),
        .target_in(target_in),
        .flush(flush),
        .stall(stall),
        .exc_pc(exc_pc),
        .is_branch_taken(is_branch_taken),
        .pht_index_out(pht_index_out),
        .pc_out(pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        is_branch_in   = 1'b0;
        is_jump_in     = 1'b0;
        is_taken_in    = 1'b0;
        is_miss_in     = 1'b0;
        last_pht_index = '0;
        inst_pc        = '0;
        target_in      = '0;
        flush          = 1'b0;
        stall          = 1'b0;
        exc_pc         = '0;
    endtask

    // Conditional-branch update while fetch is stalled; BTB writes land on an
    // entry whose tag never matches the fetch addresses used here.
    task automatic upd(input logic [7:0] idx, input logic tk);
        stall          = 1'b1;
        is_branch_in   = 1'b1;
        is_taken_in    = tk;
        last_pht_index = idx;
        inst_pc        = 32'h00001000;
        target_in      = 32'h0;
        step();
        idle();
    endtask

    // Leaves ghr = 8'h01 so that fetching 0xbfc00010 indexes PHT[5].
    task automatic settle_ghr();
        repeat (7) upd(8'h99, 1'b0);
        upd(8'h99, 1'b1);
    endtask

    task automatic redirect(input logic [31:0] addr);
        flush  = 1'b1;
        exc_pc = addr;
        step();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        chk("rst_pc_1", pc_out, 32'hbfc00000);
        step();
        chk("rst_pc_2", pc_out, 32'hbfc00000);
        chk("rst_taken", is_branch_taken, 0);
        chk("rst_idx", pht_index_out, 0);

        // Sequential fetch
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", pc_out, 32'hbfc00000 + 32'(4 * i));
            chk("seq_taken", is_branch_taken, 0);
        end
        chk("seq_idx_10", pht_index_out, 8'h04);

        // Backward-loop mispredict: redirect and train PHT[4], BTB[4]
        is_branch_in = 1'b1; is_miss_in = 1'b1; is_taken_in = 1'b1;
        inst_pc = 32'hbfc00010; target_in = 32'hbfc00000; last_pht_index = 8'h04;
        step();
        idle();
        chk("loop_redirect", pc_out, 32'hbfc00000);
        chk("loop_idx_ghr1", pht_index_out, 8'h01);

        // One more taken update to the entry the next visit will use (4 ^ 3)
        stall = 1'b1; is_branch_in = 1'b1; is_taken_in = 1'b1;
        inst_pc = 32'hbfc00010; target_in = 32'hbfc00000; last_pht_index = 8'h07;
        step();
        idle();
        chk("stall_hold", pc_out, 32'hbfc00000);
        chk("stall_idx_ghr3", pht_index_out, 8'h03);
        repeat (4) step();
        chk("loop_visit_pc", pc_out, 32'hbfc00010);
        chk("loop_visit_idx", pht_index_out, 8'h07);
        chk("loop_visit_taken", is_branch_taken, 1);
        step();
        chk("loop_predicted", pc_out, 32'hbfc00000);

        // Jump: BTB write only, ghr and PHT untouched
        stall = 1'b1; is_branch_in = 1'b1; is_jump_in = 1'b1; is_taken_in = 1'b1;
        inst_pc = 32'hbfc00020; target_in = 32'hbfc00100; last_pht_index = 8'h55;
        step();
        idle();
        chk("jump_ghr_kept", pht_index_out, 8'h03);
        redirect(32'hbfc00020);
        chk("jump_fetch_pc", pc_out, 32'hbfc00020);
        chk("jump_fetch_idx", pht_index_out, 8'h0b);
        chk("jump_taken", is_branch_taken, 1);
        step();
        chk("jump_target", pc_out, 32'hbfc00100);

        // Counter saturation on PHT[5] (starts at 2'b01)
        repeat (5) upd(8'h05, 1'b1);
        upd(8'h05, 1'b0);
        settle_ghr();
        redirect(32'hbfc00010);
        chk("sat_idx", pht_index_out, 8'h05);
        chk("sat_5t1n_taken", is_branch_taken, 1);

        repeat (2) upd(8'h05, 1'b0);
        settle_ghr();
        redirect(32'hbfc00010);
        chk("sat_to_00", is_branch_taken, 0);

        upd(8'h05, 1'b0);
        settle_ghr();
        redirect(32'hbfc00010);
        chk("sat_hold_00", is_branch_taken, 0);

        // From 00 one taken step gives 01, still not taken
        upd(8'h05, 1'b1);
        settle_ghr();
        redirect(32'hbfc00010);
        chk("sat_00_plus1", is_branch_taken, 0);

        // Priority: flush + miss + stall, updates still applied (ghr 01 -> 03)
        flush = 1'b1; exc_pc = 32'hbfc00380; stall = 1'b1;
        is_branch_in = 1'b1; is_miss_in = 1'b1; is_taken_in = 1'b1;
        inst_pc = 32'hbfc00044; target_in = 32'h80000000; last_pht_index = 8'h12;
        step();
        idle();
        chk("prio_pc", pc_out, 32'hbfc00380);
        chk("prio_ghr", pht_index_out, 8'he3);
        chk("prio_taken", is_branch_taken, 0);
        redirect(32'hbfc00044);
        chk("prio_upd_idx", pht_index_out, 8'h12);
        chk("prio_upd_taken", is_branch_taken, 1);
        step();
        chk("prio_upd_target", pc_out, 32'h80000000);

        // Not-taken mispredict falls through past the delay slot
        is_branch_in = 1'b1; is_miss_in = 1'b1; is_taken_in = 1'b0;
        inst_pc = 32'hbfc00040; target_in = 32'hdeadbeef; last_pht_index = 8'h30;
        step();
        idle();
        chk("nt_miss_pc", pc_out, 32'hbfc00048);
        redirect(32'hfffffffc);
        chk("wrap_pre", pc_out, 32'hfffffffc);
        step();
        chk("wrap_pc", pc_out, 32'h00000000);
        chk("wrap_idx", pht_index_out, 8'h06);
        chk("wrap_taken", is_branch_taken, 0);

        // Mid-run reset with a pending update
        rst = 1'b1;
        is_branch_in = 1'b1; is_taken_in = 1'b1;
        inst_pc = 32'h00000000; target_in = 32'h12345678; last_pht_index = 8'h00;
        step();
        idle();
        chk("rst2_pc", pc_out, 32'hbfc00000);
        chk("rst2_idx", pht_index_out, 0);
        chk("rst2_taken", is_branch_taken, 0);
        rst = 1'b0;
        repeat (4) step();
        chk("rst2_pc_10", pc_out, 32'hbfc00010);
        chk("rst2_idx_10", pht_index_out, 8'h04);
        chk("rst2_taken_10", is_branch_taken, 0);
        repeat (4) step();
        chk("rst2_pc_20", pc_out, 32'hbfc00020);
        chk("rst2_jump_cleared", is_branch_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
